// File: rtl/fetch_ctrl.sv
// Purpose: run-control FSM for a tiny fetch unit: loads a start address, decodes branches/halt, counts cycles.
// Latency: start one cycle after go is sampled in IDLE; branch/taken/offset are combinational from inst in RUN.
// Backpressure: none; go is ignored in LOAD/RUN and must drop in DONE before a new run. Optional watchdog: FETCH_CTRL_WATCHDOG_EN.
module fetch_ctrl (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [6:0]        program_base,
    input  logic [6:0]        pc,
    input  logic [8:0]        inst,
    input  logic              flag_we,
    input  logic              flag_in,
    output logic              start,
    output logic [6:0]        start_address,
    output logic              branch,
    output logic              taken,
    output logic signed [4:0] offset,
    output logic              busy,
    output logic              done,
    output logic [15:0]       instr_count,
    output logic              timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [6:0]  r_start_address;
    logic [15:0] r_instr_count;
    logic        r_flag;
    logic        w_is_halt;
    logic        w_is_cond;
    logic        w_is_jump;
    logic        w_wd_expired;

    // The branch target is formed by the fetch unit, so pc is not needed here.
    logic        w_unused_pc;
    assign w_unused_pc = ^pc;

    // Opcode classes; halt is the all-ones word and is carved out of the jump space.
    assign w_is_halt = (inst == 9'h1FF);
    assign w_is_cond = (inst[8:6] == 3'b110);
    assign w_is_jump = (inst[8:6] == 3'b111) && (inst[5:0] != 6'h3F);

`ifdef FETCH_CTRL_WATCHDOG_EN
    logic [9:0] r_wd_cnt;
    logic       r_timeout;

    assign w_wd_expired = (r_wd_cnt == 10'd1023);
    assign timeout      = r_timeout;

    // Watchdog counts RUN cycles from zero; the timeout flag sticks until the return to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd_cnt  <= 10'd0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: r_wd_cnt <= 10'd0;
                S_RUN: begin
                    r_wd_cnt <= r_wd_cnt + 10'd1;
                    if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!go) begin
                        r_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign w_wd_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state outputs, including the RUN-only branch decode.
    always_comb begin
        w_next_state = r_state;
        start        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        branch       = 1'b0;
        taken        = 1'b0;
        offset       = 5'sd0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                start        = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_is_cond) begin
                    branch = 1'b1;
                    // inst[5] selects branch-if-set versus branch-if-clear; uses the pre-write flag.
                    taken  = inst[5] ? ~r_flag : r_flag;
                    offset = $signed(inst[4:0]);
                end else if (w_is_jump) begin
                    branch = 1'b1;
                    taken  = 1'b1;
                    offset = $signed(inst[4:0]);
                end
                if (w_is_halt || w_wd_expired) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!go) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Start address is captured on the IDLE->LOAD edge and held through DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_start_address <= 7'd0;
        end else if ((r_state == S_IDLE) && go) begin
            r_start_address <= program_base;
        end
    end

    // Cycle counter: cleared in LOAD, saturating increment in RUN, held elsewhere.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr_count <= 16'd0;
        end else if (r_state == S_LOAD) begin
            r_instr_count <= 16'd0;
        end else if ((r_state == S_RUN) && (r_instr_count != 16'hFFFF)) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    // Condition flag written by the ALU.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else if (flag_we) begin
            r_flag <= flag_in;
        end
    end

    assign start_address = r_start_address;
    assign instr_count   = r_instr_count;

endmodule
